// File: rtl/echo_capture_ctrl_if.sv
// echo_capture_ctrl_if: control, ADC and RAM write-port bundle of the echo capture controller
interface echo_capture_ctrl_if #(
  parameter int ASIZE = 13,
  parameter int DSIZE = 8,
  parameter int DLYW  = 16,
  parameter int DECW  = 8
);
  logic             i_arm;
  logic             i_trig;
  logic [DLYW-1:0]  i_delay;
  logic [DECW-1:0]  i_decim;
  logic [ASIZE:0]   i_len;
  logic [DSIZE-1:0] i_adc_data;
  logic             i_rd_done;
  logic             o_we;
  logic [ASIZE-1:0] o_wr_addr;
  logic [DSIZE-1:0] o_data;
  logic             o_busy;
  logic             o_ready;
  logic [ASIZE:0]   o_count;
  logic [DSIZE-1:0] o_peak;
  modport master (
    output i_arm, i_trig, i_delay, i_decim, i_len, i_adc_data, i_rd_done,
    input  o_we, o_wr_addr, o_data, o_busy, o_ready, o_count, o_peak
  );
  modport slave (
    input  i_arm, i_trig, i_delay, i_decim, i_len, i_adc_data, i_rd_done,
    output o_we, o_wr_addr, o_data, o_busy, o_ready, o_count, o_peak
  );
endinterface

// File: rtl/echo_capture_ctrl.sv
// echo_capture_ctrl: gated, decimating write-side controller for the echo capture RAM
module echo_capture_ctrl #(
  parameter int ASIZE = 13,
  parameter int DSIZE = 8,
  parameter int DLYW  = 16,
  parameter int DECW  = 8
) (
  input logic                i_clk,
  input logic                i_rst_n,
  echo_capture_ctrl_if.slave bus
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ARMED   = 3'd1;
  localparam logic [2:0] DELAY   = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] DONE1   = 3'd4;
  localparam logic [2:0] READY   = 3'd5;
  localparam logic [ASIZE:0] FULL = {1'b1, {ASIZE{1'b0}}};
  logic [2:0]       state_q, state_d;
  logic             trig_q;
  logic [DLYW-1:0]  dly_q, dly_d;
  logic [DECW-1:0]  dec_q, dec_d, dcnt_q, dcnt_d;
  logic [ASIZE:0]   len_q, len_d, count_q, count_d;
  logic             we_q, we_d;
  logic [ASIZE-1:0] addr_q, addr_d;
  logic [DSIZE-1:0] data_q, data_d, peak_q, peak_d;
  logic             busy_q, ready_q;
  logic             edge_w;
  assign edge_w = bus.i_trig & ~trig_q;
  // next-state: frame sequencing, decimated sample writes and peak tracking
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    dec_d   = dec_q;
    dcnt_d  = dcnt_q;
    len_d   = len_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    peak_d  = peak_q;
    case (state_q)
      IDLE: state_d = bus.i_arm ? ARMED : IDLE;
      ARMED: begin
        if (edge_w) begin
          dly_d   = bus.i_delay;
          dec_d   = bus.i_decim;
          len_d   = (bus.i_len == '0 || bus.i_len > FULL) ? FULL : bus.i_len;
          dcnt_d  = '0;
          count_d = '0;
          peak_d  = '0;
          state_d = (bus.i_delay == '0) ? CAPTURE : DELAY;
        end
      end
      DELAY: begin
        dly_d   = dly_q - 1'b1;
        state_d = (dly_q == DLYW'(1)) ? CAPTURE : DELAY;
      end
      CAPTURE: begin
        dcnt_d = (dcnt_q == dec_q) ? '0 : dcnt_q + 1'b1;
        if (dcnt_q == '0) begin
          we_d    = 1'b1;
          data_d  = bus.i_adc_data;
          addr_d  = count_q[ASIZE-1:0];
          count_d = count_q + 1'b1;
          peak_d  = (bus.i_adc_data > peak_q) ? bus.i_adc_data : peak_q;
          state_d = (count_q + 1'b1 == len_q) ? DONE1 : CAPTURE;
        end
      end
      DONE1: state_d = READY;
      READY: state_d = bus.i_rd_done ? IDLE : READY;
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset abandons any frame in progress
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      trig_q  <= 1'b0;
      dly_q   <= '0;
      dec_q   <= '0;
      dcnt_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      peak_q  <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= bus.i_trig;
      dly_q   <= dly_d;
      dec_q   <= dec_d;
      dcnt_q  <= dcnt_d;
      len_q   <= len_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      peak_q  <= peak_d;
      busy_q  <= state_d == ARMED || state_d == DELAY || state_d == CAPTURE || state_d == DONE1;
      ready_q <= state_d == READY;
    end
  end
  assign bus.o_we      = we_q;
  assign bus.o_wr_addr = addr_q;
  assign bus.o_data    = data_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_ready   = ready_q;
  assign bus.o_count   = count_q;
  assign bus.o_peak    = peak_q;
endmodule

// File: tb/tb_echo_capture_ctrl.sv
// tb_echo_capture_ctrl: randomized frames checked every cycle against a frame-level model
module tb_echo_capture_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  echo_capture_ctrl_if bus ();
  echo_capture_ctrl dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave));
  int checks = 0;
  int failures = 0;
  int c, m_mode, first, stp, len_m, nw;
  logic m_prev;
  bit ramp;
  logic e_we;
  logic [12:0] e_addr;
  logic [7:0] e_data, e_peak;
  logic [13:0] e_count;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic model_reset();
    c = 0; m_mode = 0; m_prev = 1'b0; nw = 0;
    e_we = 1'b0; e_addr = '0; e_data = '0; e_peak = '0; e_count = '0;
  endtask

  // mode 0 idle, 1 armed, 2 frame in flight, 3 frame ready; write k lands at first + k*stp
  task automatic model_step();
    c++;
    e_we = 1'b0;
    case (m_mode)
      0: if (bus.i_arm) m_mode = 1;
      1: if (bus.i_trig && !m_prev) begin
        first = c + 1 + int'(bus.i_delay);
        stp = int'(bus.i_decim) + 1;
        len_m = (bus.i_len == 0 || bus.i_len > 14'd8192) ? 8192 : int'(bus.i_len);
        nw = 0; e_count = '0; e_peak = '0; m_mode = 2;
      end
      2: if (nw == len_m) m_mode = 3;
         else if (c >= first && (c - first) % stp == 0) begin
           e_we = 1'b1;
           e_addr = nw[12:0];
           e_data = bus.i_adc_data;
           nw++;
           e_count = nw[13:0];
           if (bus.i_adc_data > e_peak) e_peak = bus.i_adc_data;
         end
      3: if (bus.i_rd_done) m_mode = 0;
      default: m_mode = 0;
    endcase
    m_prev = bus.i_trig;
  endtask

  task automatic compare();
    chk("we", bus.o_we, e_we);
    chk("wr_addr", bus.o_wr_addr, e_addr);
    chk("data", bus.o_data, e_data);
    chk("count", bus.o_count, e_count);
    chk("peak", bus.o_peak, e_peak);
    chk("busy", bus.o_busy, m_mode == 1 || m_mode == 2);
    chk("ready", bus.o_ready, m_mode == 3);
  endtask

  task automatic step();
    @(negedge clk);
    model_step();
    compare();
    bus.i_adc_data = ramp ? bus.i_adc_data + 8'd1 : 8'($urandom);
  endtask

  task automatic zero_check();
    chk("rst_we", bus.o_we, 0);
    chk("rst_addr", bus.o_wr_addr, 0);
    chk("rst_data", bus.o_data, 0);
    chk("rst_count", bus.o_count, 0);
    chk("rst_peak", bus.o_peak, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_ready", bus.o_ready, 0);
  endtask

  task automatic run_frame(input logic [15:0] dly, input logic [7:0] dec, input logic [13:0] len,
                           input bit pre_high, input bit use_ramp);
    int n;
    bus.i_trig = pre_high;
    bus.i_arm = 1'b1;
    step();
    bus.i_arm = 1'b0;
    repeat (3) step();
    if (pre_high) begin
      chk("armed_held_busy", bus.o_busy, 1);
      chk("armed_held_no_we", bus.o_we, 0);
    end
    bus.i_trig = 1'b0;
    step();
    bus.i_delay = dly; bus.i_decim = dec; bus.i_len = len; bus.i_trig = 1'b1;
    if (use_ramp) begin
      ramp = 1'b1;
      bus.i_adc_data = 8'd9;
    end
    step();
    bus.i_delay = 16'($urandom); bus.i_decim = 8'($urandom); bus.i_len = 14'($urandom);
    n = 0;
    while (m_mode != 3 && n < 20000) begin
      bus.i_trig = 1'($urandom);
      bus.i_arm = ($urandom_range(0, 7) == 0);
      step();
      n++;
    end
    bus.i_arm = 1'b0;
    ramp = 1'b0;
    if (n >= 20000) begin
      checks++; failures++;
      $display("FAIL frame_timeout: got no ready after %0d cycles expected ready", n);
    end
    repeat (3) begin
      bus.i_trig = ~bus.i_trig;
      bus.i_arm = 1'b1;
      step();
    end
    bus.i_arm = 1'($urandom);
    bus.i_rd_done = 1'b1;
    step();
    bus.i_arm = 1'b0;
    bus.i_rd_done = 1'b0;
    step();
  endtask

  initial begin
    bus.i_arm = 0; bus.i_trig = 0; bus.i_delay = 0; bus.i_decim = 0;
    bus.i_len = 0; bus.i_adc_data = 0; bus.i_rd_done = 0;
    ramp = 1'b0;
    #3;
    zero_check();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_frame(16'd0, 8'd0, 14'd4, 1'b0, 1'b1);
    chk("t1_count", bus.o_count, 4);
    chk("t1_peak", bus.o_peak, 13);
    chk("t1_last_data", bus.o_data, 13);
    chk("t1_last_addr", bus.o_wr_addr, 3);
    run_frame(16'd5, 8'd2, 14'd3, 1'b0, 1'b0);
    chk("t2_count", bus.o_count, 3);
    chk("t2_last_addr", bus.o_wr_addr, 2);
    run_frame(16'd1, 8'd0, 14'd0, 1'b0, 1'b0);
    chk("t3_count", bus.o_count, 8192);
    chk("t3_last_addr", bus.o_wr_addr, 8191);
    run_frame(16'd3, 8'd1, 14'd5, 1'b1, 1'b0);
    chk("t4_count", bus.o_count, 5);
    run_frame(16'd0, 8'd0, 14'd12000, 1'b0, 1'b0);
    chk("len_over_count", bus.o_count, 8192);
    repeat (8) run_frame(16'($urandom_range(0, 20)), 8'($urandom_range(0, 3)),
                         14'($urandom_range(1, 40)), 1'($urandom), 1'b0);
    bus.i_arm = 1'b1;
    step();
    bus.i_arm = 1'b0;
    step();
    bus.i_delay = 16'd2; bus.i_decim = 8'd0; bus.i_len = 14'd100; bus.i_trig = 1'b1;
    step();
    repeat (10) step();
    #2 rst_n = 1'b0;
    #1 zero_check();
    model_reset();
    bus.i_trig = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_frame(16'd2, 8'd1, 14'd6, 1'b0, 1'b0);
    chk("t6_rearm_count", bus.o_count, 6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
